// File: rtl/gemm_ctrl_pkg.sv
// gemm_ctrl_pkg: shared types and defaults for the GEMM tile controller
package gemm_ctrl_pkg;
    localparam int DefAddrWidth = 12;
    localparam int DefRowPar    = 4;
    localparam int DefColPar    = 16;

    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic                    valid;
        logic                    clr;
        logic                    last;
        logic [DefAddrWidth-1:0] c_addr;
    } strobe_t;
endpackage

// File: rtl/gemm_ctrl_delay_line.sv
// gemm_ctrl_delay_line: reset-to-zero shift register aligning MAC strobes with SRAM read data
module gemm_ctrl_delay_line #(
    parameter int Depth = 1,
    parameter int Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);
    logic [Width-1:0] stage_q [Depth];

    // shift the bundle one stage per cycle, flushing to zero on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q = stage_q[Depth-1];
endmodule

// File: rtl/gemm_tile_controller.sv
// gemm_tile_controller: tiles a GEMM into RowPar x ColPar output tiles, issuing SRAM reads, MAC strobes and C writes
module gemm_tile_controller
    import gemm_ctrl_pkg::*;
#(
    parameter int AddrWidth     = DefAddrWidth,
    parameter int SizeAddrWidth = 32,
    parameter int RowPar        = DefRowPar,
    parameter int ColPar        = DefColPar,
    parameter int MemLatency    = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] K_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    output logic [AddrWidth-1:0]     sram_a_addr_o,
    output logic [AddrWidth-1:0]     sram_b_addr_o,
    output logic [AddrWidth-1:0]     sram_c_addr_o,
    output logic                     sram_c_we_o,
    output logic                     mac_valid_o,
    output logic                     mac_clr_o,
    output logic                     mac_last_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);
    localparam int          CntWidth = AddrWidth + 1;
    localparam logic [63:0] Depth    = 64'd1 << AddrWidth;

    state_t                   state_q, state_d;
    logic [SizeAddrWidth-1:0] m_sz, k_sz, n_sz, m_tiles, n_tiles;
    logic [CntWidth-1:0]      mt_q, nt_q, k_q, a_base_q, b_base_q, tile_q;
    logic [AddrWidth-1:0]     c_addr_q;
    logic                     err_q, c_we_q, reject, issuing, k_end, nt_end, mt_end;
    strobe_t                  issue_s, mac_s;

    assign m_tiles = m_sz / SizeAddrWidth'(RowPar);
    assign n_tiles = n_sz / SizeAddrWidth'(ColPar);
    assign reject  = (m_sz == '0) || (k_sz == '0) || (n_sz == '0) ||
                     (m_sz % SizeAddrWidth'(RowPar) != '0) || (n_sz % SizeAddrWidth'(ColPar) != '0) ||
                     (64'(m_tiles) * 64'(k_sz) > Depth) || (64'(n_tiles) * 64'(k_sz) > Depth) ||
                     (64'(m_tiles) * 64'(n_tiles) > Depth);
    assign issuing = state_q == ISSUE;
    assign k_end   = k_q == CntWidth'(k_sz - SizeAddrWidth'(1));
    assign nt_end  = nt_q == CntWidth'(n_tiles - SizeAddrWidth'(1));
    assign mt_end  = mt_q == CntWidth'(m_tiles - SizeAddrWidth'(1));

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // next state and the issue-stage strobe bundle; the final C write is the one not followed by a valid
    always_comb begin
        state_d        = state_q;
        issue_s        = '0;
        issue_s.valid  = issuing;
        issue_s.clr    = issuing && (k_q == '0);
        issue_s.last   = issuing && k_end;
        issue_s.c_addr = issuing ? DefAddrWidth'(tile_q) : '0;
        case (state_q)
            IDLE:    state_d = start_i ? CHECK : IDLE;
            CHECK:   state_d = reject ? DONE : ISSUE;
            ISSUE:   state_d = (k_end && nt_end && mt_end) ? DRAIN : ISSUE;
            DRAIN:   state_d = (c_we_q && !mac_s.valid) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    // size capture, error flag and the mt/nt/k loop with incrementally built base addresses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            {m_sz, k_sz, n_sz} <= '0;
            {mt_q, nt_q, k_q, a_base_q, b_base_q, tile_q} <= '0;
            err_q <= 1'b0;
        end else if (state_q == IDLE && start_i) begin
            {m_sz, k_sz, n_sz} <= {M_size_i, K_size_i, N_size_i};
            err_q <= 1'b0;
        end else if (state_q == CHECK) begin
            {mt_q, nt_q, k_q, a_base_q, b_base_q, tile_q} <= '0;
            err_q <= reject;
        end else if (issuing) begin
            if (!k_end) begin
                k_q <= k_q + CntWidth'(1);
            end else begin
                k_q    <= '0;
                tile_q <= tile_q + CntWidth'(1);
                if (!nt_end) begin
                    nt_q     <= nt_q + CntWidth'(1);
                    b_base_q <= b_base_q + CntWidth'(k_sz);
                end else begin
                    nt_q     <= '0;
                    b_base_q <= '0;
                    mt_q     <= mt_q + CntWidth'(1);
                    a_base_q <= a_base_q + CntWidth'(k_sz);
                end
            end
        end
    end

    gemm_ctrl_delay_line #(
        .Depth(MemLatency),
        .Width($bits(strobe_t))
    ) u_delay (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d     (issue_s),
        .q     (mac_s)
    );

    // C write follows the tile's last MAC cycle, while the next tile's clr-load happens alongside it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            c_we_q   <= 1'b0;
            c_addr_q <= '0;
        end else begin
            c_we_q   <= mac_s.valid && mac_s.last;
            c_addr_q <= (mac_s.valid && mac_s.last) ? AddrWidth'(mac_s.c_addr) : '0;
        end
    end

    assign sram_a_addr_o = issuing ? AddrWidth'(a_base_q + k_q) : '0;
    assign sram_b_addr_o = issuing ? AddrWidth'(b_base_q + k_q) : '0;
    assign sram_c_addr_o = c_addr_q;
    assign sram_c_we_o   = c_we_q;
    assign mac_valid_o   = mac_s.valid;
    assign mac_clr_o     = mac_s.clr;
    assign mac_last_o    = mac_s.last;
    assign busy_o        = state_q inside {CHECK, ISSUE, DRAIN};
    assign done_o        = state_q == DONE;
    assign err_o         = err_q;
endmodule

// File: tb/tb_gemm_tile_controller.sv
// tb_gemm_tile_controller: directed vector bench for the GEMM tile controller
module tb_gemm_tile_controller;
    localparam int AW   = 12;
    localparam int L    = 1;
    localparam int MAXC = 9000;

    typedef struct {
        int m;
        int k;
        int n;
        int err;
        int dcyc;
        int mode;
    } vec_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   m_sz  = '0;
    logic [31:0]   k_sz  = '0;
    logic [31:0]   n_sz  = '0;
    logic [AW-1:0] a_addr, b_addr, c_addr;
    logic          c_we, mac_valid, mac_clr, mac_last, busy, done, err;

    int            tests = 0;
    int            fails = 0;
    vec_t          vecs[14];
    logic [AW-1:0] a_tr[MAXC], b_tr[MAXC], ca_tr[MAXC];
    logic [2:0]    st_tr[MAXC], ctl_tr[MAXC];
    logic          we_tr[MAXC];
    int            ex_ab[MAXC], ex_st[MAXC], ex_we[MAXC], ex_ctl[MAXC];

    gemm_tile_controller dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .M_size_i     (m_sz),
        .K_size_i     (k_sz),
        .N_size_i     (n_sz),
        .sram_a_addr_o(a_addr),
        .sram_b_addr_o(b_addr),
        .sram_c_addr_o(c_addr),
        .sram_c_we_o  (c_we),
        .mac_valid_o  (mac_valid),
        .mac_clr_o    (mac_clr),
        .mac_last_o   (mac_last),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint pack_all();
        return longint'({a_addr, b_addr, c_addr, c_we, mac_valid, mac_clr, mac_last, busy, done, err});
    endfunction

    function automatic int act_at(input int cat, input int c);
        return cat == 0 ? int'({a_tr[c], b_tr[c]}) :
               cat == 1 ? int'(st_tr[c]) :
               cat == 2 ? int'({we_tr[c], ca_tr[c]}) : int'(ctl_tr[c]);
    endfunction

    function automatic int exp_at(input int cat, input int c);
        return cat == 0 ? ex_ab[c] : cat == 1 ? ex_st[c] : cat == 2 ? ex_we[c] : ex_ctl[c];
    endfunction

    // loop-nest model: issue index i -> (mt, nt, k) with mt outermost
    task automatic fill_expected(input vec_t v);
        int mt_n, nt_n, t, i, kk, tt, nt, mt;
        mt_n = v.m / 4;
        nt_n = v.n / 16;
        t    = v.err ? 0 : mt_n * nt_n * v.k;
        for (int c = 0; c < MAXC; c++) begin
            ex_ab[c] = 0; ex_st[c] = 0; ex_we[c] = 0;
            ex_ctl[c] = ((c >= 1 && c < v.dcyc) ? 4 : 0) | ((c == v.dcyc) ? 2 : 0) | ((c >= 2) ? v.err : 0);
            for (int s = 0; s < 3; s++) begin
                i = c - 2 - (s == 0 ? 0 : s == 1 ? L : L + 1);
                if (i >= 0 && i < t) begin
                    kk = i % v.k; tt = i / v.k; nt = tt % nt_n; mt = tt / nt_n;
                    if (s == 0) ex_ab[c] = ((mt * v.k + kk) << 12) | (nt * v.k + kk);
                    if (s == 1) ex_st[c] = 4 | ((kk == 0) ? 2 : 0) | ((kk == v.k - 1) ? 1 : 0);
                    if (s == 2 && kk == v.k - 1) ex_we[c] = (1 << 12) | (mt * nt_n + nt);
                end
            end
        end
    endtask

    task automatic run_vec(input vec_t v, output int dcyc, output int last);
        for (int c = 0; c < MAXC; c++) begin
            a_tr[c] = '0; b_tr[c] = '0; ca_tr[c] = '0; st_tr[c] = '0; ctl_tr[c] = '0; we_tr[c] = 1'b0;
        end
        m_sz = v.m; k_sz = v.k; n_sz = v.n; start = 1'b1;
        dcyc = -1;
        last = 0;
        for (int c = 1; c < MAXC; c++) begin
            @(negedge clk);
            a_tr[c] = a_addr; b_tr[c] = b_addr; ca_tr[c] = c_addr; we_tr[c] = c_we;
            st_tr[c]  = {mac_valid, mac_clr, mac_last};
            ctl_tr[c] = {busy, done, err};
            last = c;
            if (c == 1 && v.mode == 0) start = 1'b0;
            if (dcyc < 0 && done) dcyc = c;
            if (dcyc >= 0 && v.mode == 1 && c == dcyc + 1) start = 1'b0;
            if (dcyc >= 0 && v.mode == 2 && c == dcyc + 2) start = 1'b0;
            if (dcyc >= 0 && c == dcyc + 3) break;
        end
        start = 1'b0;
    endtask

    initial begin
        int dcyc, last, nd, fb, cc, d, w;
        string cat_name[4];
        cat_name = '{"ab_addr", "strobes", "c_write", "busy_done_err"};
        vecs[0]  = '{4, 64, 16, 0, 68, 0};
        vecs[1]  = '{8, 4, 32, 0, 20, 0};
        vecs[2]  = '{6, 8, 16, 1, 2, 0};
        vecs[3]  = '{4, 0, 16, 1, 2, 0};
        vecs[4]  = '{16, 3, 48, 0, 40, 0};
        vecs[5]  = '{4, 8192, 16, 1, 2, 0};
        vecs[6]  = '{4, 4096, 16, 0, 4100, 0};
        vecs[7]  = '{0, 4, 16, 1, 2, 0};
        vecs[8]  = '{4, 4, 24, 1, 2, 0};
        vecs[9]  = '{256, 1, 1040, 1, 2, 0};
        vecs[10] = '{4, 4096, 32, 1, 2, 0};
        vecs[11] = '{4, 1, 16, 0, 5, 0};
        vecs[12] = '{8, 4, 32, 0, 20, 1};
        vecs[13] = '{4, 2, 16, 0, 6, 2};

        @(negedge clk);
        check("reset_state", pack_all(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_release", pack_all(), 0);

        m_sz = 4; k_sz = 64; n_sz = 16; start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        check("pre_abort_valid_a_addr", int'({mac_valid, a_addr}), (1 << 12) | 18);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", pack_all(), 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("reset_hold_outputs %0d", c), pack_all(), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_abort", pack_all(), 0);

        for (int vi = 0; vi < 14; vi++) begin
            run_vec(vecs[vi], dcyc, last);
            d = vecs[vi].dcyc;
            check($sformatf("done_cycle v%0d", vi), dcyc, d);
            nd = 0;
            for (int c = 1; c <= last; c++) nd += int'(ctl_tr[c][1]);
            check($sformatf("done_pulses v%0d", vi), nd, 1);
            fill_expected(vecs[vi]);
            for (int cat = 0; cat < 4; cat++) begin
                fb = -1;
                for (int c = 1; c <= d; c++)
                    if (fb < 0 && act_at(cat, c) != exp_at(cat, c)) fb = c;
                cc = fb < 0 ? d : fb;
                check($sformatf("%s v%0d cyc%0d", cat_name[cat], vi, cc), act_at(cat, cc), exp_at(cat, cc));
            end
            check($sformatf("post_busy1 v%0d", vi), ctl_tr[d+1][2], 0);
            check($sformatf("post_busy2 v%0d", vi), ctl_tr[d+2][2], vecs[vi].mode == 2 ? 1 : 0);
            check($sformatf("post_err1 v%0d", vi), ctl_tr[d+1][0], vecs[vi].err);
            if (vecs[vi].mode != 2) check($sformatf("post_err3 v%0d", vi), ctl_tr[d+3][0], vecs[vi].err);
            if (vecs[vi].k == 4096 && vecs[vi].err == 0)
                check($sformatf("a_addr_max v%0d", vi), a_tr[d-2-L], 4095);
            if (vecs[vi].mode == 2) begin
                w = 0;
                while (!done && w < 200) begin
                    @(negedge clk);
                    w++;
                end
                check("second_run_done", done, 1);
                @(negedge clk);
                check("idle_after_second_run", pack_all(), 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gemm_tile_controller.md
Name: gemm_tile_controller

Overview:
Sequencer for the 4x16 output-stationary MAC array of the GEMM accelerator. It tiles an MxK by KxN product into RowPar x ColPar output tiles, generates the SRAM A/B read addresses, and drives the MAC clear/valid/last strobes aligned to read-data return. It also issues one packed C write per tile and signals completion. It sits inside gemm_accelerator_top between the start/size inputs and the MAC array plus SRAM ports.

Parameters:
AddrWidth, 12, SRAM address width (DataDepth = 2**AddrWidth)
SizeAddrWidth, 32, width of M/K/N size inputs
RowPar, 4, output rows per tile (A word = RowPar elements)
ColPar, 16, output cols per tile (B word = ColPar elements)
MemLatency, 1, SRAM read latency in cycles (>=1)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, asynchronous, active-low
start_i  in  1  start request, sampled in IDLE only
M_size_i  in  SizeAddrWidth  rows of A/C
K_size_i  in  SizeAddrWidth  inner dimension
N_size_i  in  SizeAddrWidth  cols of B/C
sram_a_addr_o  out  AddrWidth  A read address
sram_b_addr_o  out  AddrWidth  B read address
sram_c_addr_o  out  AddrWidth  C write address
sram_c_we_o  out  1  C write enable (MAC array drives wdata)
mac_valid_o  out  1  A/B rdata valid this cycle, MAC must consume
mac_clr_o  out  1  with valid: load product instead of accumulating (k==0)
mac_last_o  out  1  with valid: final k of tile
busy_o  out  1  high in CHECK/ISSUE/DRAIN
done_o  out  1  one-cycle completion pulse
err_o  out  1  last run rejected; sticky until next accepted start

Behaviour:
- Reset: every output 0, FSM IDLE, counters and pipeline cleared. Async assertion mid-run aborts immediately, with no further writes. After release, the block behaves as if freshly started.
- Memory layout: MT=M/RowPar, NT=N/ColPar. A word addr = mt*K+k. B word addr = nt*K+k. C word addr = mt*NT+nt (one 2048-bit word per tile).
- Addresses are produced by incrementing base registers and counters; no multipliers on the issue path.
- FSM states: IDLE, CHECK, ISSUE, DRAIN, DONE.
- IDLE: start_i=1 latches the sizes, clears err_o, and moves to CHECK. start_i is ignored in every other state.
- CHECK (1 cycle): reject if any size is 0, M%RowPar!=0, N%ColPar!=0, MT*K>2**AddrWidth, NT*K>2**AddrWidth, or MT*NT>2**AddrWidth. Reject goes to DONE with err_o=1. Accept goes to ISSUE.
- ISSUE: loop order mt (outer), nt, k (inner). One A/B address pair per cycle, no bubbles, including across tile boundaries. The cycle after the final address moves to DRAIN.
- Outside ISSUE, A/B addresses are 0.
- DRAIN: wait until the pipeline is empty and the last C write is issued, then go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Strobe pipeline: valid/clr/last/c_addr are delayed MemLatency cycles from issue, so mac_valid_o aligns with rdata. sram_c_we_o and sram_c_addr_o assert the cycle after mac_last_o.
- The next tile's clr-load occurs in the same cycle as the previous tile's C write; the SRAM captures the accumulator before it is overwritten.
- sram_c_addr_o is 0 when sram_c_we_o is 0.
- Latency: T=MT*NT*K issue cycles. With start sampled in cycle 0: CHECK in cycle 1, ISSUE in cycles 2..T+1, last we in cycle T+2+MemLatency, done_o in cycle T+3+MemLatency. Rejected run: done_o in cycle 2, with no valid and no we.
- Counters are wide enough for MT, NT and K up to 2**AddrWidth; there is no wrap-around within a run.

Decomposition:
- Package gemm_ctrl_pkg: FSM state enum, RowPar/ColPar defaults, strobe-bundle struct {valid, clr, last, c_addr}.
- Sub-module gemm_ctrl_delay_line: parameterised depth/width reset-to-zero shift register carrying the strobe bundle MemLatency stages.

Test Plan:
1. M=4,K=64,N=16, start pulse in cycle 0 -> a/b addr 0..63 in cycles 2..65. Valid in cycles 3..66, clr only in cycle 3, last only in cycle 66. One we at c_addr 0 in cycle 67, done_o in cycle 68, err_o=0.
2. M=8,K=4,N=32 -> a_addr 0-3,0-3,4-7,4-7 and b_addr 0-3,4-7,0-3,4-7. we at c_addr 0,1,2,3 in cycles 7,11,15,19, each coinciding with the next tile's clr. done_o in cycle 20.
3. M=6,K=8,N=16, then K=0 -> no valid/we; done_o in cycle 2; err_o=1 held until the next start, which clears it.
4. M=4,K=8192,N=16 (AddrWidth=12) -> rejected with err_o=1. M=4,K=4096,N=16 accepted, with a_addr reaching 4095.
5. Test 1 with rst_ni low in cycle 20 -> all outputs 0 asynchronously, no C write. Restart after release reproduces test 1 exactly.
6. start_i held high through a whole run and during the DONE cycle -> exactly one run. A new start is accepted only in the cycle after DONE (IDLE).
